// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: one bit per clock, logical or arithmetic fill,
// with a registered result, N/Z/C/V flags and a one-cycle done pulse.
module shift_right_seq #(
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] y,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int unsigned CW = $clog2(width + 1);
  localparam logic [width-1:0] B_MAX   = width'(width);
  localparam logic [CW-1:0]    CNT_MAX = CW'(width);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [width-1:0] work;
  logic [width-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_init;
  logic             arith_q;

  always_comb begin
    cnt_init = (b >= B_MAX) ? CNT_MAX : CW'(b);
    shifted  = {arith_q ? work[width-1] : 1'b0, work[width-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (cnt_init == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    V    = 1'b0;
  end

  // The carry out is the bit leaving bit 0 on the final shift, so it is
  // taken straight from work[0] when the result is latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      work    <= '0;
      cnt     <= '0;
      arith_q <= 1'b0;
      y       <= '0;
      N       <= 1'b0;
      Z       <= 1'b0;
      C       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work    <= a;
            cnt     <= cnt_init;
            arith_q <= arith;
            if (cnt_init == '0) begin
              y <= a;
              N <= a[width-1];
              Z <= (a == '0);
              C <= 1'b0;
            end
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            y <= shifted;
            N <= shifted[width-1];
            Z <= (shifted == '0);
            C <= work[0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
